// File: rtl/music_note_player.sv
// rtl/music_note_player.sv - song RAM sequencer producing DDS phase increments per beat
//
// Purpose: plays a song stored in an internal RAM. Each entry holds a note
// code [7:4] and a duration in beats [3:0]. A duration of 0 marks the end of
// the song. Beats come from rising edges of clk_select, which is resynchronised
// into sys_clk.
//
// Ports:
//   sys_clk    - system clock
//   sys_rst    - synchronous active-high reset
//   clk_select - beat square wave; each rising edge is one beat
//   wr_en      - song RAM write strobe
//   wr_addr    - song RAM write address
//   wr_data    - song entry {note code, duration}
//   start      - begin playback at entry 0 (ignored while busy)
//   stop       - abort playback (priority over everything else)
//   loop       - restart at entry 0 at end of song
//   freq_word  - DDS phase increment for the current note
//   tone_en    - tone enable, 0 during rests
//   note_idx   - address of the entry currently playing
//   busy       - high whenever not idle
//   done       - one-cycle pulse at natural end of song
module music_note_player #(
  parameter int ADDR_W = 5,
  parameter int FREQ_W = 24
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              clk_select,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [FREQ_W-1:0] freq_word,
  output logic              tone_en,
  output logic [ADDR_W-1:0] note_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, PLAY, DONE} state_t;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic                tone_q, tone_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [2:0]          sync_q;   // [0]=s1, [1]=s2, [2]=s3
  logic [7:0]          rd_q;
  logic [7:0]          mem [DEPTH];
  logic                beat;

  assign beat = sync_q[1] & ~sync_q[2];

  // Phase increments: round(f * 2^32 / 100 MHz) for C4..B4.
  function automatic logic [FREQ_W-1:0] note_freq(input logic [3:0] code);
    logic [31:0] v;
    case (code)
      4'd1:    v = 32'd11237;
      4'd2:    v = 32'd11905;
      4'd3:    v = 32'd12613;
      4'd4:    v = 32'd13363;
      4'd5:    v = 32'd14157;
      4'd6:    v = 32'd14999;
      4'd7:    v = 32'd15891;
      4'd8:    v = 32'd16836;
      4'd9:    v = 32'd17837;
      4'd10:   v = 32'd18898;
      4'd11:   v = 32'd20022;
      4'd12:   v = 32'd21212;
      default: v = 32'd0;
    endcase
    return v[FREQ_W-1:0];
  endfunction

  // Song RAM: not reset. Non-blocking read and write in the same edge gives
  // read-before-write on an address collision.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (state_q == FETCH) rd_q <= mem[addr_q];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    tone_d  = tone_q;
    idx_d   = idx_q;
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      freq_d  = '0;
      tone_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_d = FETCH;
            addr_d  = '0;
          end
        end
        FETCH: state_d = DECODE;
        DECODE: begin
          if (rd_q[3:0] != 4'd0) begin
            cnt_d   = rd_q[3:0];
            idx_d   = addr_q;
            freq_d  = note_freq(rd_q[7:4]);
            tone_d  = (rd_q[7:4] >= 4'd1) && (rd_q[7:4] <= 4'd12);
            state_d = PLAY;
          end else if (loop && addr_q != '0) begin
            state_d = FETCH;
            addr_d  = '0;
          end else begin
            state_d = DONE;
          end
        end
        PLAY: begin
          if (beat) begin
            if (cnt_q == 4'd1) begin
              // Running off the end of the RAM behaves like an end marker.
              if (addr_q == LAST_ADDR) begin
                if (loop && addr_q != '0) begin
                  state_d = FETCH;
                  addr_d  = '0;
                end else begin
                  state_d = DONE;
                end
              end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = FETCH;
              end
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          freq_d  = '0;
          tone_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      freq_q  <= '0;
      tone_q  <= 1'b0;
      idx_q   <= '0;
      // Preset high so a clk_select already high at release is not a beat.
      sync_q  <= 3'b111;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      tone_q  <= tone_d;
      idx_q   <= idx_d;
      sync_q  <= {sync_q[1:0], clk_select};
    end
  end

  assign freq_word = freq_q;
  assign tone_en   = tone_q;
  assign note_idx  = idx_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
